// File: rtl/axi_4_lite_master.sv
// Single-outstanding AXI4-Lite master.
// Converts one write or read command at a time into AXI4-Lite bus traffic.
module axi_4_lite_master #(
   parameter int AXI_Dwidth    = 32,
   parameter int AXI_Addrwidth = 4
) (
   input  logic                      AXI_aclk,
   input  logic                      AXI_areset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [AXI_Addrwidth-1:0]  cmd_addr,
   input  logic [AXI_Dwidth-1:0]     cmd_wdata,
   input  logic [AXI_Dwidth/8-1:0]   cmd_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_write,
   output logic [AXI_Dwidth-1:0]     rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic [7:0]                err_cnt,
   output logic [AXI_Addrwidth-1:0]  AXI_awaddr,
   output logic                      AXI_awvalid,
   input  logic                      AXI_awready,
   output logic [AXI_Dwidth-1:0]     AXI_wdata,
   output logic [AXI_Dwidth/8-1:0]   AXI_wstrb,
   output logic                      AXI_wvalid,
   input  logic                      AXI_wready,
   input  logic [1:0]                AXI_bresp,
   input  logic                      AXI_bvalid,
   output logic                      AXI_bready,
   output logic [AXI_Addrwidth-1:0]  AXI_areadaddr,
   output logic [2:0]                AXI_arprotect,
   output logic                      AXI_arvalid,
   input  logic                      AXI_arready,
   input  logic [AXI_Dwidth-1:0]     AXI_rdata,
   input  logic [1:0]                AXI_rresp,
   input  logic                      AXI_rvalid,
   output logic                      AXI_rready
);

   typedef enum logic [2:0] {
      IDLE,
      WADDR_DATA,
      WRESP,
      RADDR,
      RDATA,
      RSP
   } state_t;

   state_t state;
   logic   aw_done;
   logic   w_done;
   logic   aw_hs;
   logic   w_hs;
   logic   aw_fin;
   logic   w_fin;

   assign AXI_arprotect = 3'b000;

   // Write-channel handshakes and accumulated completion flags
   always_comb begin
      aw_hs  = AXI_awvalid & AXI_awready;
      w_hs   = AXI_wvalid & AXI_wready;
      aw_fin = aw_done | aw_hs;
      w_fin  = w_done | w_hs;
   end

   // Transaction FSM with all outputs registered
   always_ff @(posedge AXI_aclk or posedge AXI_areset) begin
      if (AXI_areset) begin
         state         <= IDLE;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_write     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b00;
         err_cnt       <= 8'd0;
         AXI_awaddr    <= '0;
         AXI_awvalid   <= 1'b0;
         AXI_wdata     <= '0;
         AXI_wstrb     <= '0;
         AXI_wvalid    <= 1'b0;
         AXI_bready    <= 1'b0;
         AXI_areadaddr <= '0;
         AXI_arvalid   <= 1'b0;
         AXI_rready    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  if (cmd_write) begin
                     AXI_awaddr  <= cmd_addr;
                     AXI_wdata   <= cmd_wdata;
                     AXI_wstrb   <= cmd_wstrb;
                     AXI_awvalid <= 1'b1;
                     AXI_wvalid  <= 1'b1;
                     aw_done     <= 1'b0;
                     w_done      <= 1'b0;
                     state       <= WADDR_DATA;
                  end else begin
                     AXI_areadaddr <= cmd_addr;
                     AXI_arvalid   <= 1'b1;
                     state         <= RADDR;
                  end
               end
            end
            WADDR_DATA: begin
               if (aw_hs) AXI_awvalid <= 1'b0;
               if (w_hs)  AXI_wvalid  <= 1'b0;
               aw_done <= aw_fin;
               w_done  <= w_fin;
               if (aw_fin && w_fin) begin
                  AXI_bready <= 1'b1;
                  state      <= WRESP;
               end
            end
            WRESP: begin
               if (AXI_bvalid) begin
                  AXI_bready <= 1'b0;
                  rsp_resp   <= AXI_bresp;
                  rsp_write  <= 1'b1;
                  rsp_rdata  <= '0;
                  rsp_valid  <= 1'b1;
                  if (AXI_bresp != 2'b00 && err_cnt != 8'hFF)
                     err_cnt <= err_cnt + 8'd1;
                  state <= RSP;
               end
            end
            RADDR: begin
               if (AXI_arready) begin
                  AXI_arvalid <= 1'b0;
                  AXI_rready  <= 1'b1;
                  state       <= RDATA;
               end
            end
            RDATA: begin
               if (AXI_rvalid) begin
                  AXI_rready <= 1'b0;
                  rsp_resp   <= AXI_rresp;
                  rsp_write  <= 1'b0;
                  rsp_rdata  <= AXI_rdata;
                  rsp_valid  <= 1'b1;
                  if (AXI_rresp != 2'b00 && err_cnt != 8'hFF)
                     err_cnt <= err_cnt + 8'd1;
                  state <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_4_lite_master.sv
// Directed bench for axi_4_lite_master.
// A behavioural register slave with configurable ready delays sits on the bus.
module tb_axi_4_lite_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [3:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [7:0]  err_cnt;
   logic [3:0]  awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int total = 0;
   int bad = 0;

   axi_4_lite_master #(.AXI_Dwidth(32), .AXI_Addrwidth(4)) dut (
      .AXI_aclk(clk), .AXI_areset(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .err_cnt(err_cnt),
      .AXI_awaddr(awaddr), .AXI_awvalid(awvalid), .AXI_awready(awready),
      .AXI_wdata(wdata), .AXI_wstrb(wstrb), .AXI_wvalid(wvalid),
      .AXI_wready(wready),
      .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready),
      .AXI_areadaddr(araddr), .AXI_arprotect(arprot),
      .AXI_arvalid(arvalid), .AXI_arready(arready),
      .AXI_rdata(rdata), .AXI_rresp(rresp), .AXI_rvalid(rvalid),
      .AXI_rready(rready)
   );

   always #5 clk = ~clk;

   // ---------------- slave model ----------------
   logic [31:0] mem [4];
   int          aw_wait = 0;
   int          w_wait = 0;
   int          ar_wait = 0;
   logic        aw_pre = 1'b0;
   logic        w_pre = 1'b0;
   logic        ar_pre = 1'b0;
   logic [1:0]  cfg_bresp = 2'b00;
   logic [3:0]  sw = 4'h0;
   int          aw_cnt, w_cnt, ar_cnt;
   logic        aw_got, w_got;
   logic [3:0]  aw_lat;
   logic [31:0] wd_lat;
   logic [3:0]  ws_lat;
   int          b_hs;
   logic        aw_now, w_now;
   logic [3:0]  a_use;
   logic [31:0] d_use;
   logic [3:0]  s_use;

   assign aw_now = aw_got | (awvalid & awready);
   assign w_now  = w_got | (wvalid & wready);
   assign a_use  = aw_got ? aw_lat : awaddr;
   assign d_use  = w_got ? wd_lat : wdata;
   assign s_use  = w_got ? ws_lat : wstrb;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
         bvalid <= 1'b0; bresp <= 2'b00;
         rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0;
         aw_lat <= '0; wd_lat <= '0; ws_lat <= '0;
         b_hs <= 0;
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else begin
         if (awvalid && awready) begin
            aw_got <= 1'b1; aw_lat <= awaddr;
            aw_cnt <= 0; awready <= aw_pre;
         end else if (aw_pre) awready <= 1'b1;
         else if (awvalid) begin
            if (aw_cnt >= aw_wait) awready <= 1'b1;
            else aw_cnt <= aw_cnt + 1;
         end else awready <= 1'b0;

         if (wvalid && wready) begin
            w_got <= 1'b1; wd_lat <= wdata; ws_lat <= wstrb;
            w_cnt <= 0; wready <= w_pre;
         end else if (w_pre) wready <= 1'b1;
         else if (wvalid) begin
            if (w_cnt >= w_wait) wready <= 1'b1;
            else w_cnt <= w_cnt + 1;
         end else wready <= 1'b0;

         if (aw_now && w_now && !bvalid) begin
            bvalid <= 1'b1; bresp <= cfg_bresp;
            aw_got <= 1'b0; w_got <= 1'b0;
            for (int i = 0; i < 4; i++)
               if (s_use[i]) mem[a_use[3:2]][8*i +: 8] <= d_use[8*i +: 8];
         end
         if (bvalid && bready) begin
            bvalid <= 1'b0; b_hs <= b_hs + 1;
         end

         if (arvalid && arready) begin
            ar_cnt <= 0; arready <= ar_pre;
            rvalid <= 1'b1; rresp <= 2'b00;
            rdata <= (araddr == 4'h4) ? {28'd0, sw} : mem[araddr[3:2]];
         end else if (ar_pre) arready <= 1'b1;
         else if (arvalid) begin
            if (ar_cnt >= ar_wait) arready <= 1'b1;
            else ar_cnt <= ar_cnt + 1;
         end else arready <= 1'b0;
         if (rvalid && rready) rvalid <= 1'b0;
      end
   end

   // ---------------- protocol monitor ----------------
   int          viol;
   logic        aw_hs_p, w_hs_p, aw_hold, w_hold;
   logic [3:0]  aw_held;
   logic [31:0] wd_held;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_hs_p <= 1'b0; w_hs_p <= 1'b0;
         aw_hold <= 1'b0; w_hold <= 1'b0;
         aw_held <= '0; wd_held <= '0;
         viol <= 0;
      end else begin
         if ((aw_hs_p && awvalid) || (w_hs_p && wvalid))
            viol <= viol + 1;
         else if (aw_hold && (!awvalid || awaddr != aw_held))
            viol <= viol + 1;
         else if (w_hold && (!wvalid || wdata != wd_held))
            viol <= viol + 1;
         aw_hs_p <= awvalid & awready;
         w_hs_p  <= wvalid & wready;
         aw_hold <= awvalid & ~awready;
         w_hold  <= wvalid & ~wready;
         aw_held <= awaddr;
         wd_held <= wdata;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output int lat);
      int k;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = w;
      cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      k = 0;
      while (!cmd_ready && k < 50) begin
         @(negedge clk); k++;
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 100) begin
         @(negedge clk); lat++;
      end
   endtask

   task automatic take();
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int lat;
      int b0;
      int rbad;
      int sbad;

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);

      // zero-wait write then read-back
      issue(1'b1, 4'h0, 32'hA5A5_0003, 4'hF, lat);
      chk("wr_latency", lat, 32'd4);
      chk("wr_rsp_write", {31'd0, rsp_write}, 32'd1);
      chk("wr_rsp_resp", {30'd0, rsp_resp}, 32'd0);
      chk("wr_rsp_rdata", rsp_rdata, 32'd0);
      chk("wr_led", {28'd0, mem[0][3:0]}, 32'h3);
      take();
      issue(1'b0, 4'h0, 32'd0, 4'h0, lat);
      chk("rd_latency", lat, 32'd4);
      chk("rd_rdata", rsp_rdata, 32'hA5A5_0003);
      chk("rd_rsp_write", {31'd0, rsp_write}, 32'd0);
      take();

      // switch register read
      sw = 4'h9;
      issue(1'b0, 4'h4, 32'd0, 4'h0, lat);
      chk("sw_rdata", rsp_rdata, 32'h0000_0009);
      chk("sw_resp", {30'd0, rsp_resp}, 32'd0);
      chk("sw_rsp_write", {31'd0, rsp_write}, 32'd0);
      take();

      // wready three cycles ahead of awready
      aw_wait = 3; w_wait = 0;
      b0 = b_hs;
      issue(1'b1, 4'h8, 32'h1234_5678, 4'h3, lat);
      chk("skew_latency", lat, 32'd7);
      take();
      chk("skew_b_count", b_hs - b0, 32'd1);
      chk("skew_mem", mem[2], 32'h0000_5678);
      chk("skew_protocol", viol, 32'd0);
      aw_wait = 0;

      // response stall with a command pending
      issue(1'b0, 4'h8, 32'd0, 4'h0, lat);
      cmd_valid = 1'b1; cmd_write = 1'b1;
      cmd_addr = 4'hC; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
      sbad = 0;
      for (int i = 0; i < 10; i++) begin
         if (!rsp_valid || rsp_rdata != 32'h0000_5678 || cmd_ready
             || awvalid || arvalid)
            sbad++;
         @(negedge clk);
      end
      chk("stall_stable", sbad, 32'd0);
      take();
      chk("stall_ready_after", {31'd0, cmd_ready}, 32'd1);
      chk("stall_no_early_aw", {31'd0, awvalid}, 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("stall_then_accept", {31'd0, awvalid}, 32'd1);
      lat = 0;
      while (!rsp_valid && lat < 100) begin
         @(negedge clk); lat++;
      end
      take();
      chk("stall_wr_mem", mem[3], 32'hDEAD_BEEF);

      // error responses saturate the counter
      cfg_bresp = 2'b10;
      rbad = 0;
      for (int i = 0; i < 300; i++) begin
         issue(1'b1, 4'hC, i, 4'hF, lat);
         if (rsp_resp != 2'b10) rbad++;
         if (i == 0) chk("err_first", {24'd0, err_cnt}, 32'd1);
         if (i == 253) chk("err_254", {24'd0, err_cnt}, 32'd254);
         if (i == 254) chk("err_255", {24'd0, err_cnt}, 32'd255);
         take();
      end
      chk("err_resp_each", rbad, 32'd0);
      chk("err_saturated", {24'd0, err_cnt}, 32'd255);
      cfg_bresp = 2'b00;

      // ready already high when valid rises
      aw_pre = 1'b1; w_pre = 1'b1; ar_pre = 1'b1;
      issue(1'b1, 4'h0, 32'h0000_0007, 4'h1, lat);
      chk("pre_wr_latency", lat, 32'd3);
      chk("pre_wr_resp", {30'd0, rsp_resp}, 32'd0);
      take();
      issue(1'b0, 4'h0, 32'd0, 4'h0, lat);
      chk("pre_rd_latency", lat, 32'd3);
      chk("pre_rd_rdata", rsp_rdata, 32'hA5A5_0007);
      take();
      aw_pre = 1'b0; w_pre = 1'b0; ar_pre = 1'b0;
      chk("err_hold_ok", {24'd0, err_cnt}, 32'd255);

      // reset in the middle of a write
      aw_wait = 20; w_wait = 20;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1;
      cmd_addr = 4'h0; cmd_wdata = 32'h1111_1111; cmd_wstrb = 4'hF;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("mid_awvalid", {31'd0, awvalid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_awvalid", {31'd0, awvalid}, 32'd0);
      chk("mid_rst_wvalid", {31'd0, wvalid}, 32'd0);
      chk("mid_rst_err", {24'd0, err_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      aw_wait = 0; w_wait = 0;
      repeat (3) @(negedge clk);
      chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      issue(1'b1, 4'h0, 32'h0000_000C, 4'h1, lat);
      chk("post_rst_latency", lat, 32'd4);
      chk("post_rst_resp", {30'd0, rsp_resp}, 32'd0);
      take();
      chk("post_rst_mem", mem[0], 32'h0000_000C);
      chk("final_protocol", viol, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_4_lite_master.md
# axi_4_lite_master

Single-outstanding AXI4-Lite master that turns simple command requests (one write or one read at a time) into AXI4-Lite bus transactions. It connects directly upstream of the `axi_4_lite` register slave and drives its write-address, write-data, write-response, read-address and read-data channels. The user-side response is returned through a valid/ready response port. A saturating error counter tracks non-OKAY bus responses.

## Interface
Parameters:
- AXI_Dwidth, 32, data width; must be 32. wstrb width is AXI_Dwidth/8.
- AXI_Addrwidth, 4, address width; matches the slave.

Ports:
- AXI_aclk  in  1  single clock; all logic on rising edge.
- AXI_areset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AXI_Addrwidth  byte address.
- cmd_wdata  in  AXI_Dwidth  write data; ignored for reads.
- cmd_wstrb  in  AXI_Dwidth/8  byte strobes; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  AXI_Dwidth  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP or RRESP.
- err_cnt  out  8  count of non-OKAY responses; saturates at 255.
- AXI_awaddr, AXI_awvalid out / AXI_awready in  AXI_Addrwidth,1,1  write-address channel.
- AXI_wdata, AXI_wstrb, AXI_wvalid out / AXI_wready in  32,4,1,1  write-data channel.
- AXI_bresp, AXI_bvalid in / AXI_bready out  2,1,1  write-response channel.
- AXI_areadaddr, AXI_arprotect, AXI_arvalid out / AXI_arready in  AXI_Addrwidth,3,1,1  read-address channel. AXI_arprotect is tied to 3'b000.
- AXI_rdata, AXI_rresp, AXI_rvalid in / AXI_rready out  32,2,1,1  read-data channel.

## Operation
- States: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RSP.
- IDLE:
  - cmd_ready = 1; all other outputs are held in their last value, with every valid/ready output at 0.
  - On acceptance, latch addr, wdata and wstrb; go to WADDR_DATA if cmd_write, otherwise RADDR.
- WADDR_DATA:
  - AXI_awvalid and AXI_wvalid rise together on entry and are tracked independently (aw_done, w_done).
  - Each valid drops the cycle after its own handshake.
  - When both handshakes have completed (same cycle or different cycles), go to WRESP.
  - The order in which awready and wready arrive is irrelevant.
- WRESP:
  - AXI_bready = 1.
  - On AXI_bvalid: capture bresp into rsp_resp, set rsp_write = 1, set rsp_rdata = 0, go to RSP.
- RADDR:
  - AXI_arvalid = 1.
  - On AXI_arready: go to RDATA.
- RDATA:
  - AXI_rready = 1.
  - On AXI_rvalid: capture rdata and rresp, set rsp_write = 0, go to RSP.
- RSP:
  - rsp_valid = 1; response fields are stable.
  - On rsp_ready: go to IDLE.
- err_cnt increments by 1 on each captured response with resp != 2'b00; it holds at 8'hFF.
- Only one transaction is outstanding at a time. No new command is accepted until the RSP handshake completes.

## Timing
- All outputs are registered. No valid depends combinationally on the corresponding ready.
- Reset values: cmd_ready = 0 while AXI_areset is asserted and 1 from the first cycle after release. Every other output resets to 0, including err_cnt.
- Once a valid is raised, its address, data and strobe are held stable until the handshake.
- A handshake is counted on a clock edge where valid and ready are both high.
- Minimum latency (zero-wait, registered-ready slave), with cmd accept at edge 0:
  - Write: awvalid/wvalid high in cycle 1; slave ready in cycle 2; bvalid in cycle 3; rsp_valid in cycle 4.
  - Read: arvalid in cycle 1; arready in cycle 2; rvalid in cycle 3; rsp_valid in cycle 4.
- Ready held high in advance is legal: if the slave's awready/wready/arready is already high in cycle 1, the handshake completes in cycle 1.
- A response that is already present on entry to WRESP/RDATA is captured on the first edge.
- Reset mid-transaction: all valid/ready outputs drop asynchronously, the state returns to IDLE, and the in-flight command is discarded (no response is produced).
- rsp_valid with rsp_ready low stalls indefinitely; the captured response is retained.

## Test plan
- Write 0x0, data 32'hA5A5_0003, strb 4'hF, to the slave: rsp_valid in cycle 4, rsp_write = 1, rsp_resp = 0; slave LED = 4'h3. A following read of 0x0 returns 32'hA5A5_0003.
- Read 0x4 with slave SW = 4'h9: rsp_rdata = 32'h0000_0009, rsp_resp = 0, rsp_write = 0.
- Model slave gives wready 3 cycles before awready: a single write completes; wvalid drops right after its handshake; awaddr is stable until awready; exactly one bvalid handshake.
- Model slave returns bresp = 2'b10 on 300 writes: err_cnt climbs to 255 and holds; rsp_resp = 2'b10 each time.
- Hold rsp_ready low for 10 cycles after a read: rsp_valid and rsp_rdata stay stable; cmd_ready stays 0; the next command is accepted only after the handshake.
- Assert AXI_areset while awvalid = 1: awvalid and wvalid go to 0 immediately; err_cnt = 0; after release a new write completes normally.
